// File: rtl/load_store_unit.sv
// Load/store unit: one data-memory transaction at a time over a req/gnt/rvalid
// handshake, with byte-lane steering for stores and extraction/extension for loads.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lsu_enable_ip,
    input  logic                  lsu_we_ip,
    input  logic [1:0]            lsu_type_ip,
    input  logic                  lsu_sign_ext_ip,
    input  logic [31:0]           lsu_wdata_ip,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_ip,
    input  logic                  lsu_addr_valid_ip,
    output logic [31:0]           lsu_rdata_op,
    output logic                  lsu_valid_op,
    output logic                  lsu_err_op,
    output logic                  lsu_busy_op,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    input  logic                  data_rvalid_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic [31:0]           data_rdata_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_t;

    // Illegal size code or an address not aligned to the access size.
    function automatic logic access_err(input logic [1:0] ty, input logic [1:0] off);
        case (ty)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = off[0];
            2'b10:   access_err = (off != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] ty, input logic [1:0] off);
        case (ty)
            2'b00:   calc_be = 4'b0001 << off;
            2'b01:   calc_be = 4'b0011 << {off[1], 1'b0};
            2'b10:   calc_be = 4'b1111;
            default: calc_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] ty, input logic [31:0] wd);
        case (ty)
            2'b00:   calc_wdata = {4{wd[7:0]}};
            2'b01:   calc_wdata = {2{wd[15:0]}};
            default: calc_wdata = wd;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then keep and extend the access size.
    function automatic logic [31:0] format_load(input logic [1:0] ty, input logic sx,
                                                input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] shifted;
        shifted = raw >> {off, 3'b000};
        case (ty)
            2'b00:   format_load = {{24{sx & shifted[7]}}, shifted[7:0]};
            2'b01:   format_load = {{16{sx & shifted[15]}}, shifted[15:0]};
            default: format_load = shifted;
        endcase
    endfunction

    lsu_state_t            state_r;
    lsu_state_t            next_state_s;
    logic                  accept_s;
    logic                  legal_accept_s;
    logic                  busy_s;
    logic [1:0]            off_r;
    logic [1:0]            type_r;
    logic                  sign_r;
    logic                  valid_r;
    logic                  err_r;
    logic [31:0]           rdata_r;
    logic                  req_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  we_r;
    logic [3:0]            be_r;
    logic [31:0]           wdata_r;

    // Next-state logic; new requests are only looked at in IDLE.
    always_comb begin
        next_state_s   = state_r;
        accept_s       = 1'b0;
        legal_accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lsu_enable_ip && lsu_addr_valid_ip) begin
                    accept_s = 1'b1;
                    if (access_err(lsu_type_ip, lsu_addr_ip[1:0])) begin
                        next_state_s = ST_ERR;
                    end else begin
                        legal_accept_s = 1'b1;
                        next_state_s   = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (data_gnt_i) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (data_rvalid_i) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Stall: combinational in the accepting cycle, state-derived afterwards.
    always_comb begin
        busy_s = 1'b0;
        if (!reset) begin
            busy_s = 1'b0;
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT)) begin
            busy_s = 1'b1;
        end else begin
            busy_s = legal_accept_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs and the latched access attributes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_r   <= 2'b00;
            type_r  <= 2'b00;
            sign_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
            req_r   <= 1'b0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            wdata_r <= 32'h0000_0000;
        end else begin
            valid_r <= (next_state_s == ST_DONE) || (next_state_s == ST_ERR);
            err_r   <= (next_state_s == ST_ERR);
            req_r   <= (next_state_s == ST_REQ);
            if (accept_s) begin
                off_r  <= lsu_addr_ip[1:0];
                type_r <= lsu_type_ip;
                sign_r <= lsu_sign_ext_ip;
            end
            if (legal_accept_s) begin
                addr_r  <= {lsu_addr_ip[ADDR_WIDTH-1:2], 2'b00};
                we_r    <= lsu_we_ip;
                be_r    <= calc_be(lsu_type_ip, lsu_addr_ip[1:0]);
                wdata_r <= calc_wdata(lsu_type_ip, lsu_wdata_ip);
            end
            // Store responses complete the access but leave the load result untouched.
            if ((state_r == ST_WAIT) && data_rvalid_i && !we_r) begin
                rdata_r <= format_load(type_r, sign_r, off_r, data_rdata_i);
            end
        end
    end

    assign lsu_rdata_op = rdata_r;
    assign lsu_valid_op = valid_r;
    assign lsu_err_op   = err_r;
    assign lsu_busy_op  = busy_s;
    assign data_req_o   = req_r;
    assign data_addr_o  = addr_r;
    assign data_we_o    = we_r;
    assign data_be_o    = be_r;
    assign data_wdata_o = wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: handshake timing, lane steering,
// load extension, error path, reset abandonment and request blocking.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        lsu_enable_ip;
    logic        lsu_we_ip;
    logic [1:0]  lsu_type_ip;
    logic        lsu_sign_ext_ip;
    logic [31:0] lsu_wdata_ip;
    logic [31:0] lsu_addr_ip;
    logic        lsu_addr_valid_ip;
    logic [31:0] lsu_rdata_op;
    logic        lsu_valid_op;
    logic        lsu_err_op;
    logic        lsu_busy_op;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    int          lat;
    logic [31:0] res;
    logic        er;
    logic        bt;
    logic        bok;
    logic        rs;
    logic        st;
    logic [31:0] ca;
    logic [3:0]  cbe;
    logic [31:0] cwd;
    logic        cwe;

    load_store_unit #(.ADDR_WIDTH(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .lsu_enable_ip     (lsu_enable_ip),
        .lsu_we_ip         (lsu_we_ip),
        .lsu_type_ip       (lsu_type_ip),
        .lsu_sign_ext_ip   (lsu_sign_ext_ip),
        .lsu_wdata_ip      (lsu_wdata_ip),
        .lsu_addr_ip       (lsu_addr_ip),
        .lsu_addr_valid_ip (lsu_addr_valid_ip),
        .lsu_rdata_op      (lsu_rdata_op),
        .lsu_valid_op      (lsu_valid_op),
        .lsu_err_op        (lsu_err_op),
        .lsu_busy_op       (lsu_busy_op),
        .data_req_o        (data_req_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_addr_o       (data_addr_o),
        .data_we_o         (data_we_o),
        .data_be_o         (data_be_o),
        .data_wdata_o      (data_wdata_o),
        .data_rdata_i      (data_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [1:0] ty, input logic sx,
                         input logic [31:0] wd, input logic [31:0] ad);
        lsu_enable_ip     = 1'b1;
        lsu_addr_valid_ip = 1'b1;
        lsu_we_ip         = we;
        lsu_type_ip       = ty;
        lsu_sign_ext_ip   = sx;
        lsu_wdata_ip      = wd;
        lsu_addr_ip       = ad;
    endtask

    task automatic idle_inputs();
        lsu_enable_ip     = 1'b0;
        lsu_addr_valid_ip = 1'b0;
    endtask

    // One access with a memory that grants after gw cycles and responds rw cycles after grant.
    task automatic do_access(input logic we, input logic [1:0] ty, input logic sx,
                             input logic [31:0] wd, input logic [31:0] ad,
                             input int gw, input int rw, input logic [31:0] rd,
                             output int o_lat, output logic [31:0] o_res, output logic o_err,
                             output logic o_bt, output logic o_bok, output logic o_rs,
                             output logic o_st, output logic [31:0] o_ca, output logic [3:0] o_cbe,
                             output logic [31:0] o_cwd, output logic o_cwe);
        int gc;
        int rc;
        int phase;
        logic first;
        gc = 0; rc = 0; phase = 0; first = 1'b1;
        o_rs = 1'b0; o_st = 1'b1; o_bok = 1'b1;
        o_ca = 32'h0; o_cbe = 4'h0; o_cwd = 32'h0; o_cwe = 1'b0;
        apply(we, ty, sx, wd, ad);
        #1;
        o_bt = lsu_busy_op;
        tick();
        idle_inputs();
        o_lat = 1;
        while (o_lat < 60 && !lsu_valid_op) begin
            o_bok = o_bok & lsu_busy_op;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (data_req_o) begin
                o_rs = 1'b1;
                if (first) begin
                    first = 1'b0;
                    o_ca = data_addr_o; o_cbe = data_be_o; o_cwd = data_wdata_o; o_cwe = data_we_o;
                end else if (data_addr_o !== o_ca || data_be_o !== o_cbe ||
                             data_wdata_o !== o_cwd || data_we_o !== o_cwe) begin
                    o_st = 1'b0;
                end
            end
            if (phase == 0) begin
                if (data_req_o) begin
                    if (gc == gw) begin
                        data_gnt_i = 1'b1;
                        phase = 1;
                    end else begin
                        gc++;
                    end
                end
            end else if (phase == 1) begin
                if (rc == rw) begin
                    data_rvalid_i = 1'b1;
                    data_rdata_i  = rd;
                    phase = 2;
                end else begin
                    rc++;
                end
            end
            tick();
            o_lat++;
        end
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        o_res = lsu_rdata_op;
        o_err = lsu_err_op;
        o_bok = o_bok & !lsu_busy_op;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        lsu_we_ip = 1'b0; lsu_type_ip = 2'b00; lsu_sign_ext_ip = 1'b0;
        lsu_wdata_ip = 32'h0; lsu_addr_ip = 32'h0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        tick();
        tick();
        chk("rst_rdata", lsu_rdata_op, 32'h0);
        chk("rst_valid", {31'h0, lsu_valid_op}, 32'h0);
        chk("rst_err", {31'h0, lsu_err_op}, 32'h0);
        chk("rst_busy", {31'h0, lsu_busy_op}, 32'h0);
        chk("rst_req", {31'h0, data_req_o}, 32'h0);
        chk("rst_be", {28'h0, data_be_o}, 32'h0);
        chk("rst_addr", data_addr_o, 32'h0);
        reset = 1'b1;
        tick();

        // Word load, zero-wait memory
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0100, 0, 0, 32'hDEAD_BEEF,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("wl_lat", 32'(lat), 32'd3);
        chk("wl_res", res, 32'hDEAD_BEEF);
        chk("wl_err", {31'h0, er}, 32'h0);
        chk("wl_addr", ca, 32'h0000_0100);
        chk("wl_be", {28'h0, cbe}, 32'hF);
        chk("wl_we", {31'h0, cwe}, 32'h0);
        chk("wl_busy_t", {31'h0, bt}, 32'h1);
        chk("wl_busy_hold", {31'h0, bok}, 32'h1);

        // Byte load at lane 3, signed then unsigned
        do_access(1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0103, 0, 0, 32'h8011_2233,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("sb_be", {28'h0, cbe}, 32'h8);
        chk("sb_addr", ca, 32'h0000_0100);
        chk("sb_res", res, 32'hFFFF_FF80);
        do_access(1'b0, 2'b00, 1'b0, 32'h0, 32'h0000_0103, 0, 0, 32'h8011_2233,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("ub_res", res, 32'h0000_0080);

        // Halfword store, grant delayed three cycles
        do_access(1'b1, 2'b01, 1'b0, 32'h1234_ABCD, 32'h0000_0102, 3, 0, 32'hFFFF_FFFF,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("hs_be", {28'h0, cbe}, 32'hC);
        chk("hs_wdata", cwd, 32'hABCD_ABCD);
        chk("hs_we", {31'h0, cwe}, 32'h1);
        chk("hs_stable", {31'h0, st}, 32'h1);
        chk("hs_lat", 32'(lat), 32'd6);
        chk("hs_res_kept", res, 32'h0000_0080);
        chk("hs_busy_hold", {31'h0, bok}, 32'h1);

        // Byte store replication and response delay
        do_access(1'b1, 2'b00, 1'b0, 32'h0000_005A, 32'h0000_0021, 0, 0, 32'h0,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("bs_be", {28'h0, cbe}, 32'h2);
        chk("bs_wdata", cwd, 32'h5A5A_5A5A);
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0104, 0, 2, 32'h0BAD_F00D,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("rv_lat", 32'(lat), 32'd5);
        chk("rv_res", res, 32'h0BAD_F00D);

        // Halfword loads, signed upper and unsigned lower
        do_access(1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_0102, 0, 0, 32'h8001_0000,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("sh_be", {28'h0, cbe}, 32'hC);
        chk("sh_res", res, 32'hFFFF_8001);
        do_access(1'b0, 2'b01, 1'b0, 32'h0, 32'h0000_0100, 0, 0, 32'h1234_F00D,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("uh_be", {28'h0, cbe}, 32'h3);
        chk("uh_res", res, 32'h0000_F00D);
        do_access(1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0101, 0, 0, 32'h0000_7F00,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("pb_res", res, 32'h0000_007F);

        // Error path: misaligned word, illegal type, misaligned half
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0101, 0, 0, 32'h0,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("mw_lat", 32'(lat), 32'd1);
        chk("mw_err", {31'h0, er}, 32'h1);
        chk("mw_req", {31'h0, rs}, 32'h0);
        chk("mw_busy_t", {31'h0, bt}, 32'h0);
        chk("mw_busy_v", {31'h0, bok}, 32'h1);
        do_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0000_0100, 0, 0, 32'h0,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("ty_lat", 32'(lat), 32'd1);
        chk("ty_err", {31'h0, er}, 32'h1);
        chk("ty_req", {31'h0, rs}, 32'h0);
        chk("ty_busy_t", {31'h0, bt}, 32'h0);
        do_access(1'b1, 2'b01, 1'b0, 32'h0, 32'h0000_0103, 0, 0, 32'h0,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("mh_err", {31'h0, er}, 32'h1);
        chk("mh_req", {31'h0, rs}, 32'h0);

        // Reset while waiting for the response
        apply(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0200);
        tick();
        idle_inputs();
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("rw_wait_req", {31'h0, data_req_o}, 32'h0);
        chk("rw_wait_busy", {31'h0, lsu_busy_op}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rw_req", {31'h0, data_req_o}, 32'h0);
        chk("rw_be", {28'h0, data_be_o}, 32'h0);
        chk("rw_addr", data_addr_o, 32'h0);
        chk("rw_rdata", lsu_rdata_op, 32'h0);
        chk("rw_busy", {31'h0, lsu_busy_op}, 32'h0);
        chk("rw_valid", {31'h0, lsu_valid_op}, 32'h0);
        tick();
        reset = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0000_0055;
        tick();
        data_rvalid_i = 1'b0;
        chk("rw_stray_valid", {31'h0, lsu_valid_op}, 32'h0);
        tick();
        chk("rw_stray_valid2", {31'h0, lsu_valid_op}, 32'h0);
        chk("rw_stray_rdata", lsu_rdata_op, 32'h0);
        do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0300, 0, 0, 32'hCAFE_F00D,
                  lat, res, er, bt, bok, rs, st, ca, cbe, cwd, cwe);
        chk("rw_next_lat", 32'(lat), 32'd3);
        chk("rw_next_res", res, 32'hCAFE_F00D);

        // Enable held high across an outstanding access
        apply(1'b0, 2'b10, 1'b0, 32'h0, 32'h0000_0400);
        tick();
        chk("eh_req1", {31'h0, data_req_o}, 32'h1);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        chk("eh_wait_req", {31'h0, data_req_o}, 32'h0);
        chk("eh_wait_busy", {31'h0, lsu_busy_op}, 32'h1);
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h1111_1111;
        tick();
        data_rvalid_i = 1'b0;
        chk("eh_done_valid", {31'h0, lsu_valid_op}, 32'h1);
        chk("eh_done_busy", {31'h0, lsu_busy_op}, 32'h0);
        chk("eh_done_req", {31'h0, data_req_o}, 32'h0);
        chk("eh_done_rdata", lsu_rdata_op, 32'h1111_1111);
        tick();
        chk("eh_idle_valid", {31'h0, lsu_valid_op}, 32'h0);
        chk("eh_idle_req", {31'h0, data_req_o}, 32'h0);
        chk("eh_idle_busy", {31'h0, lsu_busy_op}, 32'h1);
        tick();
        chk("eh_req2", {31'h0, data_req_o}, 32'h1);
        chk("eh_addr2", data_addr_o, 32'h0000_0400);
        idle_inputs();
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h2222_2222;
        tick();
        data_rvalid_i = 1'b0;
        chk("eh_valid2", {31'h0, lsu_valid_op}, 32'h1);
        chk("eh_rdata2", lsu_rdata_op, 32'h2222_2222);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
